logicnet_lut_neuron_pipe: RTL and testbench

- Parametrised, run-time-loadable LogicNet neuron: a 2^IN_BITS x OUT_BITS truth table held in distributed RAM.
- The table is loaded serially over a config stream. Lookups then run through a valid/ready pipeline with one registered stage.
- Replaces the fixed combinational per-neuron ROMs in the synthesised layers, so retrained tables can be loaded without resynthesis.

---
 rtl/logicnet_lut_neuron_pipe.sv | 130 +++++++++++++
 tb/tb_logicnet_lut_neuron_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logicnet_lut_neuron_pipe.sv
// Run-time loadable LogicNet neuron: serially loaded truth table, one-stage valid/ready lookup.
// Define LOGICNET_LUT_PARITY_EN to store an even-parity bit per entry and flag mismatches.
module logicnet_lut_neuron_pipe #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_ready,
  output logic                table_loaded,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
`ifdef LOGICNET_LUT_PARITY_EN
  input  logic                cfg_inject_err,
  output logic                parity_err,
`endif
  output logic [CNT_W-1:0]    lookup_count
);

  localparam int DEPTH = 1 << IN_BITS;
`ifdef LOGICNET_LUT_PARITY_EN
  localparam int ENTRY_W = OUT_BITS + 1;
`else
  localparam int ENTRY_W = OUT_BITS;
`endif

  typedef enum logic [1:0] {
    UNLOADED,
    LOADING,
    READY
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [IN_BITS-1:0]   load_addr;
  logic [ENTRY_W-1:0]   lut_mem [DEPTH];
  logic [ENTRY_W-1:0]   wr_entry;
  logic [ENTRY_W-1:0]   rd_entry;
  logic                 wr_en;
  logic                 accept;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNLOADED;
    end else begin
      state <= state_next;
    end
  end

  // a cfg_start always wins over a load write, so a restart never also advances the address
  always_comb begin
    state_next = state;
    case (state)
      UNLOADED: if (cfg_start) state_next = LOADING;
      LOADING:  if (!cfg_start && cfg_valid && (&load_addr)) state_next = READY;
      READY:    if (cfg_start) state_next = LOADING;
      default:  state_next = UNLOADED;
    endcase
  end

  always_comb begin
    cfg_ready    = (state == LOADING);
    table_loaded = (state == READY);
    in_ready     = (state == READY) && (!out_valid || out_ready);
  end

  assign wr_en  = (state == LOADING) && cfg_valid && !cfg_start;
  assign accept = in_valid && in_ready;

`ifdef LOGICNET_LUT_PARITY_EN
  assign wr_entry = {(^cfg_data) ^ cfg_inject_err, cfg_data};
`else
  assign wr_entry = cfg_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      load_addr <= '0;
    end else if (cfg_start) begin
      load_addr <= '0;
    end else if (wr_en) begin
      load_addr <= load_addr + IN_BITS'(1);
    end
  end

  // table contents deliberately survive reset; only load writes touch them
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lut_mem[load_addr] <= wr_entry;
    end
  end

  assign rd_entry = lut_mem[in_data];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
`ifdef LOGICNET_LUT_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= rd_entry[OUT_BITS-1:0];
`ifdef LOGICNET_LUT_PARITY_EN
      parity_err <= ^rd_entry;
`endif
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_count <= '0;
    end else if (accept && (lookup_count != {CNT_W{1'b1}})) begin
      lookup_count <= lookup_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logicnet_lut_neuron_pipe.sv
// Scoreboard bench for logicnet_lut_neuron_pipe: loads, lookups, backpressure, reload, counter saturation.
// With LOGICNET_LUT_PARITY_EN defined it also checks parity injection.
`timescale 1ns/1ps
module tb_logicnet_lut_neuron_pipe;

  localparam int IN_BITS  = 8;
  localparam int OUT_BITS = 1;
  localparam int CNT_W    = 4;
  localparam int DEPTH    = 256;

  logic                clk;
  logic                rst;
  logic                cfg_start;
  logic                cfg_valid;
  logic [OUT_BITS-1:0] cfg_data;
  logic                cfg_ready;
  logic                table_loaded;
  logic                in_valid;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;
  logic [CNT_W-1:0]    lookup_count;
`ifdef LOGICNET_LUT_PARITY_EN
  logic                cfg_inject_err;
  logic                parity_err;
  localparam int INJECT_ADDR = 5;
`else
  localparam int INJECT_ADDR = -1;
`endif

  int         tests_run;
  int         tests_failed;
  int         acc_count;
  logic       model_tbl [DEPTH];
  logic       model_inj [DEPTH];
  logic [1:0] exp_q [$];
  logic [1:0] mon_exp;

  logicnet_lut_neuron_pipe #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_valid     (cfg_valid),
    .cfg_data      (cfg_data),
    .cfg_ready     (cfg_ready),
    .table_loaded  (table_loaded),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
`ifdef LOGICNET_LUT_PARITY_EN
    .cfg_inject_err(cfg_inject_err),
    .parity_err    (parity_err),
`endif
    .lookup_count  (lookup_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // kind 0 = parity of address, 1 = all ones, 2 = all zeros
  function automatic logic entryValue(input int kind, input int addr);
    logic [7:0] a;
    a = addr[7:0];
    case (kind)
      0:       return ^a;
      1:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] expCount();
    return (acc_count > 15) ? 32'd15 : 32'(acc_count);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic loadTable(input int kind, input int nwrites, input int inject_addr, input bit do_start);
    if (do_start) begin
      @(posedge clk);
      #1;
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
    end
    checkOutput("cfg_ready_load", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < nwrites; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = entryValue(kind, i);
`ifdef LOGICNET_LUT_PARITY_EN
      cfg_inject_err = (i == inject_addr);
`endif
      model_tbl[i] = entryValue(kind, i);
      model_inj[i] = (i == inject_addr);
      if (i == DEPTH - 1) begin
        @(negedge clk);
        checkOutput("loaded_before_last", 32'(table_loaded), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
`ifdef LOGICNET_LUT_PARITY_EN
    cfg_inject_err = 1'b0;
`endif
    if (nwrites == DEPTH) begin
      checkOutput("loaded_after_last", 32'(table_loaded), 32'd1);
      checkOutput("cfg_ready_done", 32'(cfg_ready), 32'd0);
    end else begin
      checkOutput("loaded_partial", 32'(table_loaded), 32'd0);
    end
  endtask

  task automatic applyStimulus(input int addr);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = addr[7:0];
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back({model_inj[addr], model_tbl[addr]});
    acc_count++;
    #1;
    in_valid = 1'b0;
    checkOutput("lat_valid", 32'(out_valid), 32'd1);
  endtask

  // scoreboard: every completed output handshake is matched against the queued expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("out_data", 32'(out_data), 32'(mon_exp[0]));
`ifdef LOGICNET_LUT_PARITY_EN
        checkOutput("parity_err", 32'(parity_err), 32'(mon_exp[1]));
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    acc_count    = 0;
    rst          = 1'b1;
    cfg_start    = 1'b0;
    cfg_valid    = 1'b0;
    cfg_data     = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b1;
`ifdef LOGICNET_LUT_PARITY_EN
    cfg_inject_err = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_table_loaded", 32'(table_loaded), 32'd0);
    checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_count", 32'(lookup_count), 32'd0);
    rst = 1'b0;

    loadTable(0, DEPTH, INJECT_ADDR, 1'b1);
    applyStimulus(8'h00);
    applyStimulus(8'h03);
    applyStimulus(8'h07);
    applyStimulus(8'hFF);
    idle(2);
    checkOutput("count_basic", 32'(lookup_count), expCount());

`ifdef LOGICNET_LUT_PARITY_EN
    applyStimulus(8'h05);
    applyStimulus(8'h04);
    idle(2);
`endif

    out_ready = 1'b0;
    applyStimulus(8'h07);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_data", 32'(out_data), 32'(model_tbl[7]));
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    checkOutput("in_ready_release", 32'(in_ready), 32'd1);
    idle(1);
    checkOutput("valid_clear", 32'(out_valid), 32'd0);

    loadTable(0, 100, -1, 1'b1);
    loadTable(1, DEPTH, -1, 1'b1);
    applyStimulus(8'h00);
    idle(2);

    loadTable(0, DEPTH, -1, 1'b1);
    in_valid  = 1'b1;
    in_data   = 8'h01;
    cfg_start = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_concurrent", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back({model_inj[1], model_tbl[1]});
    acc_count++;
    #1;
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    checkOutput("in_ready_reload", 32'(in_ready), 32'd0);
    checkOutput("cfg_ready_reload", 32'(cfg_ready), 32'd1);
    loadTable(2, DEPTH, -1, 1'b0);
    applyStimulus(8'h01);
    idle(2);

    for (int n = 0; n < 20; n++) begin
      applyStimulus(int'($urandom_range(0, 255)));
    end
    idle(2);
    checkOutput("count_sat", 32'(lookup_count), expCount());

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst2_count", 32'(lookup_count), 32'd0);
    checkOutput("rst2_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst2_table_loaded", 32'(table_loaded), 32'd0);
    checkOutput("rst2_in_ready", 32'(in_ready), 32'd0);
    checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
